my74ls191_divider: RTL and testbench
====================================

# my74ls191_divider

Cascadable synchronous up/down counter with parallel load, borrow/carry chaining and an auto-reload register. It is the count-down companion to the team's 4-bit up counter: its Bo output and BI input form the borrow/carry chain across stages, and it serves as a programmable divide-by-N tick source. In auto-reload mode it reloads from a held value instead of wrapping.

## Interface
- WIDTH, 4, counter and data width in bits (≥2)
- CP  in  1  clock, all state updates on rising edge
- CR  in  1  reset; synchronous, active-high; clears Q, reload register and Tc
- D  in  WIDTH  parallel data for load and for reload-register write
- Ld  in  1  active-low synchronous parallel load, Q <= D
- RlWe  in  1  active-high write of reload register Rl <= D
- CTEN  in  1  active-high local count enable
- BI  in  1  active-high chain enable (borrow/carry from less-significant stage; tie 1 on first stage)
- DnUp  in  1  direction, 1 = count down, 0 = count up
- AutoRl  in  1  1 = at terminal count reload Q from Rl; 0 = wrap
- Q  out  WIDTH  counter value
- MaxMin  out  1  combinational terminal flag: (DnUp & Q==0) | (~DnUp & Q==all ones)
- Bo  out  1  combinational chain out = MaxMin & CTEN & BI
- Tc  out  1  registered one-cycle pulse, terminal step taken

## Operation
- Internal state: Q (WIDTH), Rl (WIDTH), Tc (1).
- Step = CTEN & BI & Ld (counting is active only when not loading).
- Per rising CP edge, Q priority: CR -> 0; else ~Ld -> D; else Step & MaxMin & AutoRl -> Rl; else Step -> Q-1 (DnUp=1) or Q+1 (DnUp=0), modulo 2^WIDTH; else hold.
- Rl: CR -> 0; else RlWe -> D; else hold. Independent of Ld and of counting.
- Tc: CR -> 0; else Tc <= Step & MaxMin (evaluated pre-edge, for both AutoRl values).
- Arithmetic is WIDTH-bit unsigned; wrap 0 -> all ones (down) and all ones -> 0 (up) when AutoRl=0.
- Cascading: stage k BI = Bo of stage k-1, all stages share CP, CTEN, DnUp; the ripple-free chain makes the whole cascade count as one wide counter.
- Divide-by-N (1 ≤ N ≤ 2^WIDTH): DnUp=1, AutoRl=1, Rl=N-1, CTEN=BI=1 -> Tc high once every N cycles. Rl=0 -> Tc high every cycle, Q stays 0.

## Timing
- Reset values: Q=0, Rl=0, Tc=0; MaxMin=DnUp, Bo=DnUp&CTEN&BI (combinational from reset state).
- Load and count latency: 1 cycle (Q valid after the edge).
- MaxMin/Bo: zero latency, follow Q, DnUp, CTEN, BI combinationally.
- Tc: asserted the cycle after the terminal step edge, exactly 1 cycle wide per terminal step.
- Simultaneous RlWe and reload-at-terminal: Q takes the OLD Rl; new Rl is used from the next terminal.
- Simultaneous ~Ld and RlWe: Q <= D and Rl <= D on the same edge.
- ~Ld while at terminal with enable high: load wins, Tc <= 0.
- DnUp change: takes effect on the same edge; MaxMin re-evaluates immediately.
- CR mid-count: on the next edge state returns to reset values regardless of Ld/RlWe/enables. A pending Tc is dropped.
- CTEN=0 or BI=0: Q, Tc hold/clear as defined; Rl writes still occur.

## Test plan
- Reset: apply CR=1 for 2 cycles with Ld=0, D=4'hA, RlWe=1 -> Q=0, Rl=0, Tc=0. After release with DnUp=1: MaxMin=1.
- Down wrap: load Q=4'h2, DnUp=1, AutoRl=0, enables=1 -> Q sequence 1, 0, F, E. Tc high only the cycle after 0->F. Bo high while Q=0.
- Divide-by-5: Rl=4, load Q=4, DnUp=1, AutoRl=1 -> Q cycles 4,3,2,1,0,4,… and Tc period is exactly 5 cycles.
- Up counting and Rl collision: DnUp=0, AutoRl=1, Rl=3, Q=F. Assert RlWe with D=9 on the terminal edge -> Q=3 (old Rl). The next terminal reloads to 9.
- Cascade: two WIDTH=4 instances chained Bo->BI, load 8'h01, count down -> 8'h00, 8'hFF, 8'hFE. The high stage decrements only on the edge where the low stage Bo=1.
- Priority and hold: with Q=5, set CTEN=0 -> Q holds 5. Ld=0, D=7, CTEN=1 -> Q=7, no step. CR=1 together with Ld=0 -> Q=0.

Source files
------------

// File: rtl/my74ls191_divider_if.sv
// my74ls191_divider_if: data, control and status bundle for one counter stage
interface my74ls191_divider_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] i_d;
  logic             i_ld;
  logic             i_rl_we;
  logic             i_cten;
  logic             i_bi;
  logic             i_dn_up;
  logic             i_auto_rl;
  logic [WIDTH-1:0] o_q;
  logic             o_max_min;
  logic             o_bo;
  logic             o_tc;
  modport master (
    output i_d, i_ld, i_rl_we, i_cten, i_bi, i_dn_up, i_auto_rl,
    input  o_q, o_max_min, o_bo, o_tc
  );
  modport slave (
    input  i_d, i_ld, i_rl_we, i_cten, i_bi, i_dn_up, i_auto_rl,
    output o_q, o_max_min, o_bo, o_tc
  );
endinterface

// File: rtl/my74ls191_divider.sv
// my74ls191_divider: cascadable up/down counter with parallel load and auto-reload tick
module my74ls191_divider #(parameter int WIDTH = 4) (
  input logic                  i_cp,
  input logic                  i_cr,
  my74ls191_divider_if.slave   bus
);
  logic [WIDTH-1:0] r_q, r_rl, w_q_nxt;
  logic             r_tc, w_step, w_max_min;
  assign w_max_min     = bus.i_dn_up ? (r_q == '0) : (&r_q);
  assign w_step        = bus.i_cten & bus.i_bi & bus.i_ld;
  assign bus.o_q       = r_q;
  assign bus.o_max_min = w_max_min;
  assign bus.o_bo      = w_max_min & bus.i_cten & bus.i_bi;
  assign bus.o_tc      = r_tc;
  // reload uses the pre-edge Rl, so a same-edge RlWe only affects the next terminal
  always_comb
    w_q_nxt = !bus.i_ld                       ? bus.i_d :
              (w_step & w_max_min & bus.i_auto_rl) ? r_rl :
              w_step ? (bus.i_dn_up ? r_q - 1'b1 : r_q + 1'b1) : r_q;
  always_ff @(posedge i_cp) begin
    if (i_cr) begin
      r_q  <= '0;
      r_rl <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_rl <= bus.i_rl_we ? bus.i_d : r_rl;
      r_tc <= w_step & w_max_min;
    end
  end
endmodule

// File: tb/tb_my74ls191_divider.sv
// tb_my74ls191_divider: table-driven vectors plus cascade and combinational-flag sequences
module tb_my74ls191_divider;
  typedef struct {
    logic       cr, ld;
    logic [3:0] d;
    logic       rw, cten, bi, dn, ar;
    logic [3:0] eq;
    logic       emm, ebo, etc;
  } vec_t;
  logic cp = 1'b0;
  logic cr;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  my74ls191_divider_if #(.WIDTH(4)) bus ();
  my74ls191_divider_if #(.WIDTH(4)) lo ();
  my74ls191_divider_if #(.WIDTH(4)) hi ();
  my74ls191_divider #(.WIDTH(4)) u_dut (.i_cp(cp), .i_cr(cr), .bus(bus));
  my74ls191_divider #(.WIDTH(4)) u_lo  (.i_cp(cp), .i_cr(cr), .bus(lo));
  my74ls191_divider #(.WIDTH(4)) u_hi  (.i_cp(cp), .i_cr(cr), .bus(hi));
  assign hi.i_bi = lo.o_bo;
  always #5 cp = ~cp;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic cr_, ld_, input logic [3:0] d_, input logic rw_, cten_, bi_, dn_, ar_,
                     input logic [3:0] q_, input logic mm_, bo_, tc_);
    vec_t v;
    v = '{cr_, ld_, d_, rw_, cten_, bi_, dn_, ar_, q_, mm_, bo_, tc_};
    vecs.push_back(v);
  endtask
  task automatic cas_set(input logic ld_, input logic [3:0] dl, dh);
    lo.i_ld = ld_; hi.i_ld = ld_; lo.i_d = dl; hi.i_d = dh;
  endtask
  initial begin
    cr = 1'b1;
    {bus.i_d, bus.i_ld, bus.i_rl_we, bus.i_cten, bus.i_bi, bus.i_dn_up, bus.i_auto_rl} = {4'h0, 6'b100000};
    {lo.i_rl_we, lo.i_cten, lo.i_bi, lo.i_dn_up, lo.i_auto_rl} = 5'b00010;
    {hi.i_rl_we, hi.i_cten, hi.i_dn_up, hi.i_auto_rl} = 4'b0010;
    cas_set(1'b1, 4'h0, 4'h0);
    // reset with load and reload-write asserted, then Rl=0 auto-reload every cycle
    add(1,0,4'hA,1,1,1,1,0, 4'h0,1,1,0);
    add(1,0,4'hA,1,1,1,1,0, 4'h0,1,1,0);
    add(0,1,4'h0,0,1,1,1,1, 4'h0,1,1,1);
    // down wrap
    add(0,0,4'h2,0,1,1,1,0, 4'h2,0,0,0);
    add(0,1,4'h0,0,1,1,1,0, 4'h1,0,0,0);
    add(0,1,4'h0,0,1,1,1,0, 4'h0,1,1,0);
    add(0,1,4'h0,0,1,1,1,0, 4'hF,0,0,1);
    add(0,1,4'h0,0,1,1,1,0, 4'hE,0,0,0);
    // divide-by-5 with simultaneous load and reload write
    add(0,0,4'h4,1,1,1,1,1, 4'h4,0,0,0);
    for (int i = 0; i < 2; i++) begin
      add(0,1,4'h0,0,1,1,1,1, 4'h3,0,0,0);
      add(0,1,4'h0,0,1,1,1,1, 4'h2,0,0,0);
      add(0,1,4'h0,0,1,1,1,1, 4'h1,0,0,0);
      add(0,1,4'h0,0,1,1,1,1, 4'h0,1,1,0);
      add(0,1,4'h0,0,1,1,1,1, 4'h4,0,0,1);
    end
    // up counting, reload-write collision at terminal
    add(0,1,4'h3,1,0,1,0,1, 4'h4,0,0,0);
    add(0,0,4'hF,0,1,1,0,1, 4'hF,1,1,0);
    add(0,1,4'h9,1,1,1,0,1, 4'h3,0,0,1);
    add(0,1,4'h0,0,1,1,0,1, 4'h4,0,0,0);
    add(0,0,4'hE,0,1,1,0,1, 4'hE,0,0,0);
    add(0,1,4'h0,0,1,1,0,1, 4'hF,1,1,0);
    add(0,1,4'h0,0,1,1,0,1, 4'h9,0,0,1);
    // priority, hold, load at terminal, BI=0 with Rl write, reset dropping Tc
    add(0,0,4'h5,0,1,1,0,1, 4'h5,0,0,0);
    add(0,1,4'h0,0,0,1,0,1, 4'h5,0,0,0);
    add(0,0,4'h7,0,1,1,1,1, 4'h7,0,0,0);
    add(0,0,4'h0,0,1,1,1,1, 4'h0,1,1,0);
    add(0,0,4'hB,0,1,1,1,1, 4'hB,0,0,0);
    add(0,1,4'h2,1,1,0,1,1, 4'hB,0,0,0);
    add(0,0,4'h0,0,1,1,1,1, 4'h0,1,1,0);
    add(0,1,4'h0,0,1,1,1,1, 4'h2,0,0,1);
    add(1,0,4'h7,1,1,1,1,1, 4'h0,1,1,0);
    add(0,1,4'h0,0,1,1,1,1, 4'h0,1,1,1);
    foreach (vecs[i]) begin
      @(negedge cp);
      cr = vecs[i].cr;
      {bus.i_ld, bus.i_d, bus.i_rl_we, bus.i_cten, bus.i_bi, bus.i_dn_up, bus.i_auto_rl} =
        {vecs[i].ld, vecs[i].d, vecs[i].rw, vecs[i].cten, vecs[i].bi, vecs[i].dn, vecs[i].ar};
      @(posedge cp); #1;
      chk($sformatf("vec%0d", i), {1'b0, bus.o_q, bus.o_max_min, bus.o_bo, bus.o_tc},
          {1'b0, vecs[i].eq, vecs[i].emm, vecs[i].ebo, vecs[i].etc});
    end
    // MaxMin and Bo follow DnUp and CTEN with no clock edge (Q=0 here)
    @(negedge cp); bus.i_ld = 1'b0; bus.i_d = 4'h0; bus.i_dn_up = 1'b0; #1;
    chk("mm_up_q0", {6'd0, bus.o_max_min, bus.o_bo}, 8'd0);
    bus.i_dn_up = 1'b1; #1;
    chk("mm_dn_q0", {6'd0, bus.o_max_min, bus.o_bo}, 8'd3);
    bus.i_cten = 1'b0; #1;
    chk("bo_cten0", {6'd0, bus.o_max_min, bus.o_bo}, 8'd2);
    // two-stage cascade counting down from 8'h01
    @(negedge cp);
    lo.i_cten = 1'b1; lo.i_bi = 1'b1; lo.i_dn_up = 1'b1; hi.i_cten = 1'b1; hi.i_dn_up = 1'b1;
    cas_set(1'b0, 4'h1, 4'h0);
    @(posedge cp); #1;
    chk("cas_load", {hi.o_q, lo.o_q}, 8'h01);
    chk("cas_bi_hi", {7'd0, hi.i_bi}, 8'd0);
    @(negedge cp); cas_set(1'b1, 4'h0, 4'h0);
    @(posedge cp); #1;
    chk("cas_00", {hi.o_q, lo.o_q}, 8'h00);
    chk("cas_bo", {6'd0, lo.o_bo, hi.o_bo}, 8'd3);
    @(posedge cp); #1;
    chk("cas_ff", {hi.o_q, lo.o_q}, 8'hFF);
    chk("cas_tc", {6'd0, lo.o_tc, hi.o_tc}, 8'd3);
    @(posedge cp); #1;
    chk("cas_fe", {hi.o_q, lo.o_q}, 8'hFE);
    chk("cas_tc2", {6'd0, lo.o_tc, hi.o_tc}, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
